prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//   Boot-time program loader that fills the instruction memory the core fetches from.
//   Consumes a byte stream (valid/ready), assembles NBINST-bit instruction words and
//   writes them to consecutive instruction addresses starting at 0.
//   Holds the core in reset until a complete, checksum-verified image is in memory.
//   Sits directly upstream of the core's instruction port, via the instruction RAM.
// PARAMETERS
//   NBINST = 16  : instruction word width in bits (opcode+operand)
//   MINSTW = 9   : instruction memory address width
//   NWORDS = 512 : instruction memory depth; largest legal word count
//   NBYTES = (NBINST+7)/8 : bytes per word (derived, do not override)
// PORTS
//   clk        in   1       : system clock, all logic on posedge
//   rst        in   1       : synchronous reset, ACTIVE-LOW
//   start      in   1       : 1-cycle pulse, begin a load (honoured only in IDLE/DONE/ERR)
//   byte_in    in   8       : stream data
//   byte_valid in   1       : stream data valid
//   byte_ready out  1       : loader can accept; a transfer happens when valid&ready at posedge
//   wr_en      out  1       : instruction memory write strobe (1 cycle per word)
//   wr_addr    out  MINSTW  : instruction memory write address
//   wr_data    out  NBINST  : instruction word to write
//   core_rst   out  1       : active-high reset to core; 1 except in DONE
//   busy       out  1       : 1 in HDR0/HDR1/DATA/CHK
//   done       out  1       : 1 in DONE (image valid, core released)
//   err        out  1       : 1 in ERR (bad length or checksum)
// BEHAVIOUR
//   Reset (rst==0 at posedge): state=IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0,
//     core_rst=1, busy=0, done=0, err=0, word count/byte index/checksum cleared.
//     Reset mid-load aborts; partially written memory is left as is.
//   Frame: CNT_H, CNT_L (16-bit word count N, big-endian), N*NBYTES data bytes
//     (each word MSB byte first; NBINST<8*NBYTES keeps the low NBINST bits), then CHK.
//   CHK must equal the 8-bit modulo-256 sum of CNT_H, CNT_L and all data bytes.
//   FSM: IDLE -start-> HDR0 -xfer-> HDR1 -xfer-> {ERR if N>NWORDS; CHK if N==0; else DATA}
//     DATA: shifts bytes in; after the NBYTES-th byte of word k: wr_data=word, wr_addr=k,
//       wr_en=1 exactly in the next cycle; after word N-1 -> CHK.
//     CHK -xfer-> DONE if sum matches, else ERR.
//     DONE/ERR -start-> HDR0 (reload; core_rst re-asserted the cycle after start).
//   byte_ready=1 in HDR0, HDR1, DATA, CHK only; bytes offered in IDLE/DONE/ERR are not taken.
//   byte_ready is registered and not gated by byte_valid; gaps in byte_valid stall with no effect.
//   State outputs (busy/done/err/core_rst) are registered and change the cycle after
//     the causing transfer; the transfer itself completes on that edge.
//   start while busy: ignored. start in the same cycle as rst==0: reset wins.
//   wr_addr is MINSTW bits; N<=NWORDS<=2^MINSTW guarantees no wrap.
//   Checksum accumulator is 8 bits, wraps silently.
// TESTING (NBINST=16, NWORDS=512)
//   1. start; bytes 00 02 12 34 AB CD C0 -> wr_en @addr0=0x1234, @addr1=0xABCD;
//      done=1, core_rst=0, err=0.
//   2. Same frame with CHK=C1 -> both writes occur, then err=1, core_rst stays 1, done=0.
//   3. start; bytes 00 00 00 -> no wr_en; done=1 the cycle after CHK transfer.
//   4. start; bytes 02 01 (N=513) -> err=1 after 2nd byte; byte_ready=0, no wr_en.
//   5. Case 1 with byte_valid toggling 1/0 and 3-cycle gaps, plus bytes driven in IDLE
//      before start -> identical writes and done; IDLE bytes not accepted.
//   6. rst=0 after first word written in DATA -> all outputs at reset values;
//      new start + case-1 frame loads correctly.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream interface feeding the program loader.
//   byte_in    : stream data byte
//   byte_valid : source has a byte on byte_in
//   byte_ready : loader will take the byte at the next posedge
// Handshake: a byte moves on a posedge where byte_valid && byte_ready are both 1.
//   The source holds byte_in stable while byte_valid is 1 and not yet taken.
//   byte_ready does not depend on byte_valid.
// Modports: master = byte source, slave = loader.
interface prog_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader. Receives a framed byte stream
//   CNT_H, CNT_L, N*NBYTES data bytes (MSB byte first per word), CHK
// writes N words to instruction memory at addresses 0..N-1 and keeps the
// core in reset until the whole image has arrived with a matching checksum.
// Ports:
//   clk, rst (sync, active-low) : clock and reset
//   start                       : pulse to begin a load (IDLE/DONE/ERR only)
//   bs                          : byte stream (slave side)
//   wr_en/wr_addr/wr_data       : instruction memory write port
//   core_rst                    : active-high core reset, low only in DONE
//   busy/done/err               : load status
//   dbg_state                   : current FSM state, for observation
module prog_loader #(
  parameter int NBINST = 16,
  parameter int MINSTW = 9,
  parameter int NWORDS = 512,
  localparam int NBYTES = (NBINST + 7) / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  prog_loader_if.slave      bs,
  output logic              wr_en,
  output logic [MINSTW-1:0] wr_addr,
  output logic [NBINST-1:0] wr_data,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  localparam int SW  = 8 * NBYTES;
  localparam int BIW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [15:0] NW16 = 16'(NWORDS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       widx_q, widx_d;
  logic [BIW-1:0]    bidx_q, bidx_d;
  logic [SW-1:0]     shift_q, shift_d;
  logic [7:0]        sum_q, sum_d;
  logic              wr_en_q, wr_en_d;
  logic [MINSTW-1:0] wr_addr_q, wr_addr_d;
  logic [NBINST-1:0] wr_data_q, wr_data_d;
  logic              act_q, done_q, err_q, core_rst_q;

  logic        xfer;
  logic [15:0] n_w;
  logic        last_byte;
  logic        last_word;

  // act_q is the registered byte_ready, so xfer needs no combinational path
  // from byte_valid back to byte_ready.
  assign xfer      = act_q & bs.byte_valid;
  assign n_w       = {cnt_q[15:8], bs.byte_in};
  assign last_byte = (bidx_q == BIW'(NBYTES - 1));
  assign last_word = (widx_q == (cnt_q - 16'd1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    widx_d    = widx_q;
    bidx_d    = bidx_q;
    shift_d   = shift_q;
    sum_d     = sum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR0;
          cnt_d   = '0;
          widx_d  = '0;
          bidx_d  = '0;
          shift_d = '0;
          sum_d   = '0;
        end
      end
      S_HDR0: begin
        if (xfer) begin
          cnt_d   = {bs.byte_in, 8'h00};
          sum_d   = sum_q + bs.byte_in;
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          cnt_d = n_w;
          sum_d = sum_q + bs.byte_in;
          if (n_w > NW16)       state_d = S_ERR;
          else if (n_w == 16'd0) state_d = S_CHK;
          else                   state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          sum_d   = sum_q + bs.byte_in;
          shift_d = (shift_q << 8) | SW'(bs.byte_in);
          if (last_byte) begin
            // Word complete: write strobe appears in the following cycle.
            bidx_d    = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = widx_q[MINSTW-1:0];
            wr_data_d = shift_d[NBINST-1:0];
            widx_d    = widx_q + 16'd1;
            if (last_word) state_d = S_CHK;
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end
      end
      S_CHK: begin
        if (xfer) state_d = (bs.byte_in == sum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      widx_q     <= '0;
      bidx_q     <= '0;
      shift_q    <= '0;
      sum_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      act_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      widx_q     <= widx_d;
      bidx_q     <= bidx_d;
      shift_q    <= shift_d;
      sum_q      <= sum_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      // Status flops load from the next state so they move together with it.
      act_q      <= (state_d == S_HDR0) || (state_d == S_HDR1) ||
                    (state_d == S_DATA) || (state_d == S_CHK);
      done_q     <= (state_d == S_DONE);
      err_q      <= (state_d == S_ERR);
      core_rst_q <= (state_d != S_DONE);
    end
  end

  assign bs.byte_ready = act_q;
  assign busy          = act_q;
  assign done          = done_q;
  assign err           = err_q;
  assign core_rst      = core_rst_q;
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  prog_loader_if lif();

  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [15:0] wr_data;
  logic        core_rst, busy, done, err;
  logic [2:0]  dbg_state;

  prog_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bs        (lif),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .core_rst  (core_rst),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [24:0] exp_q[$];
  logic [24:0] got_q[$];

  always @(negedge clk) if (wr_en === 1'b1) got_q.push_back({wr_addr, wr_data});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_wr_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk({tag, "_wr"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"},    32'(lif.byte_ready), 32'd0);
    chk({tag, "_wr_en"},    32'(wr_en),          32'd0);
    chk({tag, "_wr_addr"},  32'(wr_addr),        32'd0);
    chk({tag, "_wr_data"},  32'(wr_data),        32'd0);
    chk({tag, "_core_rst"}, 32'(core_rst),       32'd1);
    chk({tag, "_busy"},     32'(busy),           32'd0);
    chk({tag, "_done"},     32'(done),           32'd0);
    chk({tag, "_err"},      32'(err),            32'd0);
    chk({tag, "_state"},    32'(dbg_state),      32'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles; returns #1 after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    lif.byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    lif.byte_in    = b;
    lif.byte_valid = 1'b1;
    t = 0;
    while (lif.byte_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) chk("ready_timeout", 32'(lif.byte_ready), 32'd1);
    @(posedge clk);
    #1 lif.byte_valid = 1'b0;
  endtask

  // Case-1 frame; gapped=1 inserts alternating 1- and 3-cycle valid gaps.
  task automatic send_good_frame(input bit gapped);
    logic [7:0] fr[7];
    fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
    for (int i = 0; i < 7; i++)
      send_byte(fr[i], gapped ? ((i % 2 == 0) ? 1 : 3) : 0);
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_done"},     32'(done),     32'd1);
    chk({tag, "_core_rst"}, 32'(core_rst), 32'd0);
    chk({tag, "_err"},      32'(err),      32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
  endtask

  // ---------------- global bound ----------------
  initial begin
    #200000;
    $display("FAIL global_timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation bound exceeded");
  end

  // ---------------- directed sequence ----------------
  initial begin
    lif.byte_in    = 8'h00;
    lif.byte_valid = 1'b0;

    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset("reset");
    @(negedge clk) rst = 1'b1;

    // Case 1: two-word image
    pulse_start();
    chk("c1_busy_after_start",  32'(busy),           32'd1);
    chk("c1_ready_after_start", 32'(lif.byte_ready), 32'd1);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    chk("c1_wr0_en",   32'(wr_en),   32'd1);
    chk("c1_wr0_addr", 32'(wr_addr), 32'd0);
    chk("c1_wr0_data", 32'(wr_data), 32'h1234);
    send_byte(8'hAB, 0);
    chk("c1_wr_gap", 32'(wr_en), 32'd0);
    send_byte(8'hCD, 0);
    chk("c1_wr1_en",   32'(wr_en),   32'd1);
    chk("c1_wr1_addr", 32'(wr_addr), 32'd1);
    chk("c1_wr1_data", 32'(wr_data), 32'hABCD);
    chk("c1_busy_before_chk", 32'(busy), 32'd1);
    send_byte(8'hC0, 0);
    check_done("c1");
    exp_q.push_back({9'd0, 16'h1234});
    exp_q.push_back({9'd1, 16'hABCD});
    check_log("c1");

    // Case 2: bad checksum (reload from DONE)
    pulse_start();
    chk("c2_core_rst_reasserted", 32'(core_rst), 32'd1);
    chk("c2_done_cleared",        32'(done),     32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    send_byte(8'hC1, 0);
    chk("c2_err",      32'(err),      32'd1);
    chk("c2_done",     32'(done),     32'd0);
    chk("c2_core_rst", 32'(core_rst), 32'd1);
    chk("c2_ready",    32'(lif.byte_ready), 32'd0);
    exp_q.push_back({9'd0, 16'h1234});
    exp_q.push_back({9'd1, 16'hABCD});
    check_log("c2");

    // Case 3: empty image (reload from ERR)
    pulse_start();
    chk("c3_err_cleared", 32'(err), 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("c3_state_chk", 32'(dbg_state), 32'd4);
    send_byte(8'h00, 0);
    check_done("c3");
    check_log("c3");

    // Case 4: length 513 rejected after second header byte
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h01, 0);
    chk("c4_err",   32'(err),            32'd1);
    chk("c4_ready", 32'(lif.byte_ready), 32'd0);
    chk("c4_busy",  32'(busy),           32'd0);
    @(negedge clk);
    lif.byte_in    = 8'h77;
    lif.byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("c4_ready_held", 32'(lif.byte_ready), 32'd0);
    chk("c4_state_err",  32'(dbg_state),      32'd6);
    lif.byte_valid = 1'b0;
    check_log("c4");

    // Case 5: bytes offered in IDLE, then a gapped stream
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    lif.byte_in    = 8'h55;
    lif.byte_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("c5_idle_ready", 32'(lif.byte_ready), 32'd0);
    chk("c5_idle_state", 32'(dbg_state),      32'd0);
    lif.byte_valid = 1'b0;
    pulse_start();
    send_good_frame(1'b1);
    check_done("c5");
    exp_q.push_back({9'd0, 16'h1234});
    exp_q.push_back({9'd1, 16'hABCD});
    check_log("c5");

    // Case 6: reset after the first word, with start asserted alongside reset
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    chk("c6_wr0_en", 32'(wr_en), 32'd1);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 check_reset("c6_reset");
    start = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("c6_idle_after_reset", 32'(dbg_state), 32'd0);
    exp_q.push_back({9'd0, 16'h1234});
    check_log("c6_partial");
    pulse_start();
    send_good_frame(1'b0);
    check_done("c6");
    exp_q.push_back({9'd0, 16'h1234});
    exp_q.push_back({9'd1, 16'hABCD});
    check_log("c6");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
